// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART framed image loader writing instruction memory
// Optional trailing XOR checksum is enabled by defining LOADER_CHECKSUM_EN.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_WORDS  = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RX,
  output logic        IM_WE,
  output logic [31:0] IM_ADDR,
  output logic [31:0] IM_WD,
  output logic        CPU_RST,
  output logic        BUSY,
  output logic        LOAD_DONE,
  output logic        LOAD_ERR
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE, S_ERROR
  } state_t;

  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_active;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, rx_ferr;

  // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_active <= 1'b0; bit_cnt <= 4'd0; timer <= '0;
      rx_shift <= 8'd0; rx_byte <= 8'd0; rx_valid <= 1'b0; rx_ferr <= 1'b0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_s2) begin
          rx_active <= 1'b1;
          bit_cnt   <= 4'd0;
          timer     <= '0;
        end
      end else if (timer == ((bit_cnt == 4'd0) ? HALF_M1 : FULL_M1)) begin
        timer <= '0;
        if (bit_cnt == 4'd0) begin
          if (rx_s2) rx_active <= 1'b0;
          else       bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          rx_active <= 1'b0;
          rx_byte   <= rx_shift;
          rx_valid  <= rx_s2;
          rx_ferr   <= !rx_s2;
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  state_t      state, state_next;
  logic [7:0]  n_words, word_idx;
  logic [1:0]  byte_sel;
  logic [31:0] word_buf;
  logic        do_sync, do_count, do_data, do_write;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        xor_acc <= 8'd0;
    else if (do_count) xor_acc <= 8'd0;
    else if (do_data)  xor_acc <= xor_acc ^ rx_byte;
  end
`endif

  always_comb begin
    state_next = state;
    do_sync    = 1'b0;
    do_count   = 1'b0;
    do_data    = 1'b0;
    do_write   = 1'b0;
    case (state)
      S_IDLE:
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_next = S_COUNT;
          do_sync    = 1'b1;
        end
      S_COUNT:
        if (rx_ferr) state_next = S_ERROR;
        else if (rx_valid) begin
          if (rx_byte == 8'd0 || rx_byte > 8'(DEPTH_WORDS)) state_next = S_ERROR;
          else begin
            state_next = S_DATA;
            do_count   = 1'b1;
          end
        end
      S_DATA:
        if (rx_ferr) state_next = S_ERROR;
        else if (rx_valid) begin
          do_data = 1'b1;
          if (byte_sel == 2'd3) begin
            do_write = 1'b1;
            if (word_idx == n_words - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_next = S_CHECK;
`else
              state_next = S_DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:
        if (rx_ferr) state_next = S_ERROR;
        else if (rx_valid) state_next = (rx_byte == xor_acc) ? S_DONE : S_ERROR;
`endif
      S_DONE:
        if (rx_ferr) state_next = S_ERROR;
        else if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_next = S_COUNT;
          do_sync    = 1'b1;
        end
      S_ERROR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE; n_words <= 8'd0; word_idx <= 8'd0; byte_sel <= 2'd0;
      word_buf <= 32'd0; IM_WE <= 1'b0; IM_ADDR <= 32'd0; IM_WD <= 32'd0;
      LOAD_ERR <= 1'b0;
    end else begin
      state <= state_next;
      IM_WE <= do_write;
      if (state_next == S_ERROR) LOAD_ERR <= 1'b1;
      else if (do_sync)          LOAD_ERR <= 1'b0;
      if (do_count) begin
        n_words  <= rx_byte;
        word_idx <= 8'd0;
        byte_sel <= 2'd0;
      end
      if (do_data) begin
        word_buf[{byte_sel, 3'b000} +: 8] <= rx_byte;
        byte_sel <= byte_sel + 2'd1;
      end
      if (do_write) begin
        IM_ADDR  <= {22'd0, word_idx, 2'b00};
        IM_WD    <= {rx_byte, word_buf[23:0]};
        word_idx <= word_idx + 8'd1;
      end
    end
  end

  // The processor runs only while a complete image is resident
  assign CPU_RST   = (state != S_DONE);
  assign LOAD_DONE = (state == S_DONE);
  assign BUSY      = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - randomized frame bench for imem_uart_loader
// Honors LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_uart_loader;

  localparam int CPB   = 4;
  localparam int DEPTH = 64;
  localparam int GAP   = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        RX = 1'b1;
  logic        IM_WE;
  logic [31:0] IM_ADDR, IM_WD;
  logic        CPU_RST, BUSY, LOAD_DONE, LOAD_ERR;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX(RX), .IM_WE(IM_WE), .IM_ADDR(IM_ADDR),
    .IM_WD(IM_WD), .CPU_RST(CPU_RST), .BUSY(BUSY), .LOAD_DONE(LOAD_DONE),
    .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    bit          last;
  } wr_t;

  int checks = 0;
  int failures = 0;

  wr_t         exp_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wd[$];
  logic [7:0]  frm[$];

  // Frame-level reference: what the loader must have done after each byte
  bit          m_in_frame = 0, m_need_count = 0, m_done = 0, m_err = 0;
  int          m_n = 0, m_idx = 0;
  logic [7:0]  m_xor = 8'd0;
  logic [31:0] m_word = 32'd0;
  bit          exp_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_need_count = 0; m_done = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_abort();
    m_in_frame = 0; m_done = 0; m_err = 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    wr_t w;
    if (!m_in_frame) begin
      if (!ok) begin
        if (m_done) model_abort();
      end else if (b == 8'hA5) begin
        m_in_frame = 1; m_need_count = 1; m_done = 0; m_err = 0;
      end
    end else if (!ok) begin
      model_abort();
    end else if (m_need_count) begin
      if (b == 8'd0 || int'(b) > DEPTH) model_abort();
      else begin
        m_need_count = 0; m_n = int'(b); m_idx = 0; m_xor = 8'd0;
      end
    end else if (m_idx < 4 * m_n) begin
      m_word[8 * (m_idx % 4) +: 8] = b;
      m_xor = m_xor ^ b;
      m_idx++;
      if (m_idx % 4 == 0) begin
        w.addr = 32'(4 * (m_idx / 4 - 1));
        w.wd   = m_word;
        w.last = (m_idx == 4 * m_n);
        exp_q.push_back(w);
`ifndef LOADER_CHECKSUM_EN
        if (w.last) begin m_in_frame = 0; m_done = 1; end
`endif
      end
    end else begin
      if (b == m_xor) begin m_in_frame = 0; m_done = 1; end
      else model_abort();
    end
  endtask

  wr_t         cmp_e;
  logic [31:0] last_addr = 32'd0, last_wd = 32'd0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("rst_we", {31'd0, IM_WE}, 32'd0);
      chk("rst_addr", IM_ADDR, 32'd0);
      chk("rst_wd", IM_WD, 32'd0);
      chk("rst_cpu_rst", {31'd0, CPU_RST}, 32'd1);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_done", {31'd0, LOAD_DONE}, 32'd0);
      chk("rst_err", {31'd0, LOAD_ERR}, 32'd0);
      last_addr = 32'd0;
      last_wd = 32'd0;
    end else begin
      if (IM_WE) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'd1, 32'd0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("wr_addr", IM_ADDR, cmp_e.addr);
          chk("wr_data", IM_WD, cmp_e.wd);
`ifndef LOADER_CHECKSUM_EN
          if (cmp_e.last) begin
            chk("last_wr_cpu_rst", {31'd0, CPU_RST}, 32'd0);
            chk("last_wr_done", {31'd0, LOAD_DONE}, 32'd1);
          end
`endif
        end
        obs_addr.push_back(IM_ADDR);
        obs_wd.push_back(IM_WD);
        last_addr = IM_ADDR;
        last_wd = IM_WD;
      end else begin
        chk("addr_hold", IM_ADDR, last_addr);
        chk("wd_hold", IM_WD, last_wd);
      end
      if (exp_valid) begin
        chk("cpu_rst", {31'd0, CPU_RST}, {31'd0, !m_done});
        chk("load_done", {31'd0, LOAD_DONE}, {31'd0, m_done});
        chk("load_err", {31'd0, LOAD_ERR}, {31'd0, m_err});
        chk("busy", {31'd0, BUSY}, {31'd0, m_in_frame});
      end
    end
  end

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (CPB) @(posedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    exp_valid = 0;
    model_byte(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    RX = 1'b1;
    repeat (GAP) @(posedge CLK);
    exp_valid = 1;
  endtask

  task automatic send_frame(input int bad_idx);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], i != bad_idx);
      if (i > 0 && !m_in_frame) break;
    end
  endtask

  task automatic glitch();
    RX = 1'b0;
    @(posedge CLK);
    RX = 1'b1;
    repeat (3 * CPB) @(posedge CLK);
  endtask

  task automatic build_frame(input logic [7:0] cnt, input int nw, input logic [7:0] ck_flip);
    logic [7:0] x, b;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(cnt);
    x = 8'd0;
    for (int i = 0; i < 4 * nw; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      frm.push_back(b);
    end
`ifdef LOADER_CHECKSUM_EN
    frm.push_back(x ^ ck_flip);
`endif
  endtask

  task automatic load_literal(input logic [7:0] ck);
    frm = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    frm.push_back(ck);
`endif
  endtask

  int base, r, nw, bad;
  logic [7:0] cnt, g, flip;

  initial begin
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    model_reset();
    exp_valid = 1;
    repeat (200) @(posedge CLK);
    glitch();

    // Reference image from hand-assembled words
    base = obs_addr.size();
    load_literal(8'hC0);
    send_frame(-1);
    chk("dir_nwrites", 32'(obs_addr.size() - base), 32'd2);
    if (obs_addr.size() - base == 2) begin
      chk("dir_addr0", obs_addr[base], 32'h0);
      chk("dir_data0", obs_wd[base], 32'h00500013);
      chk("dir_addr1", obs_addr[base + 1], 32'h4);
      chk("dir_data1", obs_wd[base + 1], 32'h00100093);
    end
    chk("dir_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    chk("dir_done", {31'd0, LOAD_DONE}, 32'd1);
    send_byte(8'h13, 1'b1);

    // Reload with a single word
    base = obs_addr.size();
    frm = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    frm.push_back(8'h22);
`endif
    send_byte(frm[0], 1'b1);
    chk("reload_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    frm.delete(0);
    send_frame(-1);
    chk("reload_nwrites", 32'(obs_addr.size() - base), 32'd1);
    if (obs_addr.size() - base == 1) chk("reload_data", obs_wd[base], 32'hDEADBEEF);
    chk("reload_done", {31'd0, LOAD_DONE}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    load_literal(8'hC1);
    send_frame(-1);
    chk("badck_err", {31'd0, LOAD_ERR}, 32'd1);
    chk("badck_cpu_rst", {31'd0, CPU_RST}, 32'd1);
`endif

    build_frame(8'h00, 1, 8'h00);
    send_frame(-1);
    chk("cnt0_err", {31'd0, LOAD_ERR}, 32'd1);
    build_frame(8'h41, 1, 8'h00);
    send_frame(-1);
    chk("cnt41_err", {31'd0, LOAD_ERR}, 32'd1);
    chk("cnt41_cpu_rst", {31'd0, CPU_RST}, 32'd1);

    build_frame(8'h02, 2, 8'h00);
    send_frame(4);
    chk("ferr_err", {31'd0, LOAD_ERR}, 32'd1);
    load_literal(8'hC0);
    send_frame(-1);
    chk("after_ferr_done", {31'd0, LOAD_DONE}, 32'd1);

    // Reset between bytes of word 1
    frm = '{8'hA5, 8'h02, 8'h13, 8'h00};
    send_frame(-1);
    exp_valid = 0;
    #3 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    model_reset();
    @(posedge CLK);
    exp_valid = 1;
    repeat (50) @(posedge CLK);

    for (int f = 0; f < 25; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, m_done ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) glitch();
      r = $urandom_range(0, 7);
      if (r == 0)      cnt = 8'd0;
      else if (r == 1) cnt = 8'($urandom_range(DEPTH + 1, 255));
      else             cnt = 8'($urandom_range(1, 4));
      nw = (cnt >= 8'd1 && int'(cnt) <= DEPTH) ? int'(cnt) : 1;
      flip = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      build_frame(cnt, nw, flip);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(1, frm.size() - 1) : -1;
      send_frame(bad);
    end

    repeat (20) @(posedge CLK);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Serial program loader that writes the processor's instruction memory from a UART byte stream. It receives a framed image, assembles little-endian 32-bit words and issues single-cycle word writes to the instruction memory write port. It holds the processor in reset until a complete, valid image has been written. It sits beside the instruction memory: the loader is the write side, and the processor's fetch path is the read side.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; must be ≤ 255.
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RX  in  1  UART receive line; asynchronous, idles high.
- IM_WE  out  1  instruction memory write strobe, one cycle per word.
- IM_ADDR  out  32  byte address of the word being written; always word-aligned.
- IM_WD  out  32  write data; valid while IM_WE=1.
- CPU_RST  out  1  active-high reset to the processor (PCCounter, RST_RF, RST_DM).
- BUSY  out  1  frame reception in progress (any state other than IDLE/DONE).
- LOAD_DONE  out  1  last frame loaded successfully; level signal.
- LOAD_ERR  out  1  last frame aborted; level signal.

## Operation
- Frame format: sync 0xA5, count N (words, 1..DEPTH_WORDS), 4·N data bytes (LSB first per word), then an optional checksum (see Configuration).
- UART receiver:
  - RX passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer; the start bit is resampled at CLKS_PER_BIT/2. If it is high, the edge is a glitch: ignore it and return to line idle.
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT apart at mid-bit.
  - The stop bit is sampled at mid-bit. If it is low, that is a framing error.
  - The receiver produces an internal one-cycle byte-valid at the stop-bit sample.
- FSM states: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
  - IDLE: bytes other than 0xA5 are discarded. 0xA5 → COUNT, and the state clears LOAD_DONE and LOAD_ERR.
  - COUNT: byte N=0 or N>DEPTH_WORDS → ERROR; otherwise latch N, set the word address to 0 → DATA.
  - DATA: shift each byte into bits [8k+7:8k] for k=0..3. After the 4th byte:
    - pulse IM_WE with IM_ADDR=4·index and IM_WD=the assembled word;
    - increment the index;
    - after word N, go to CHECK if LOADER_CHECKSUM_EN is defined, else DONE.
  - CHECK: compare the received byte with the running XOR of all data bytes. Equal → DONE; otherwise → ERROR.
  - DONE: CPU_RST=0, LOAD_DONE=1. A new 0xA5 byte reasserts CPU_RST and enters COUNT (reload).
  - ERROR: CPU_RST=1, LOAD_ERR=1; go to IDLE the next cycle. LOAD_ERR stays set until the next sync byte.
- A framing error in any state other than IDLE → ERROR. A framing error in IDLE is discarded.
- Words already written before an abort remain in memory. Because CPU_RST stays 1, a partial image is never executed.

## Timing
- Reset values:
  - IM_WE=0, IM_ADDR=0, IM_WD=0
  - CPU_RST=1, BUSY=0, LOAD_DONE=0, LOAD_ERR=0
  - FSM=IDLE, receiver idle
- RX-to-sample latency: 2 cycles of synchronizer.
- IM_WE: asserts the cycle after the 4th byte's byte-valid and lasts exactly 1 cycle. IM_ADDR and IM_WD are held stable until the next write.
- CPU_RST falls the cycle after the final byte's byte-valid. That byte is the last data byte without the checksum, or the checksum byte with it.
- CPU_RST rises the cycle after a sync byte is accepted in DONE.
- Reset mid-frame: RST_N low immediately forces all reset values. No further write occurs, and the frame must be resent from the sync byte.
- The RX bit counter restarts on every start edge; there is no inter-byte timeout.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state and the 8-bit XOR accumulator are present.
  - The frame carries a trailing checksum byte.
  - A mismatch → ERROR, LOAD_ERR=1, CPU_RST stays 1.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no accumulator.
  - DATA goes to DONE directly after word N.
  - Any extra byte arriving in DONE is ignored unless it is 0xA5.

## Test plan
- Reset, then idle line → CPU_RST=1, IM_WE=0, BUSY=0 indefinitely.
- CLKS_PER_BIT=4, frame A5 02 13 00 50 00 93 00 10 00 (+ checksum C0 when enabled):
  - two IM_WE pulses: addr 0x0 data 0x00500013, then addr 0x4 data 0x00100093;
  - CPU_RST=0 and LOAD_DONE=1 one cycle after the final byte.
- With LOADER_CHECKSUM_EN, same frame with checksum 0xC1 → both writes occur, then LOAD_ERR=1, CPU_RST=1, FSM back in IDLE.
- Count byte 0x00, or 0x41 with DEPTH_WORDS=64 → LOAD_ERR=1, no IM_WE, CPU_RST=1.
- Stop bit driven low on the 3rd data byte → ERROR, no IM_WE for that word, LOAD_ERR=1. A following valid frame then loads normally.
- After a successful load, send A5 01 + one word → CPU_RST reasserts the cycle after the sync byte is accepted; the single word is written at addr 0x0; CPU_RST releases after the frame ends.
- RST_N pulsed low between bytes of word 1 → all outputs return to reset values, with no write and no spurious byte.
